// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 34-cycle fixed latency.
// Optional MULDIV_EARLY_OUT_EN: a zero divisor/multiplier skips straight to DONE (latency 1).
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [2:0]        Funct3,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  input  logic [ADDR_W-1:0] Rd_In,
  output logic              Busy,
  output logic              Done,
  output logic [XLEN-1:0]   Result,
  output logic [ADDR_W-1:0] Rd_Out,
  output logic              WE_Out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [5:0]      CNT_LAST = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   rd_q, rd_d, rdo_q, rdo_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic                div0_q, div0_d, ovf_q, ovf_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic                early, sgn_a, sgn_b;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_s, rem_s;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = Start && (SrcB == '0);
`else
  assign early = 1'b0;
`endif

  assign sgn_a = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
  assign sgn_b = Funct3[2] ? ~Funct3[0] : ~Funct3[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = early ? DONE : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state_q == CALC) || (state_q == FIX);
    Done   = (state_q == DONE);
    WE_Out = (state_q == DONE);
  end

  always_comb begin
    f3_d = f3_q;  rd_d = rd_q;  rdo_d = rdo_q;
    neg_a_d = neg_a_q;  neg_b_d = neg_b_q;  div0_d = div0_q;  ovf_d = ovf_q;
    mag_a_d = mag_a_q;  mag_b_d = mag_b_q;  acc_d = acc_q;  cnt_d = cnt_q;  res_d = res_q;
    mul_sum = '0;  div_sh = '0;  div_diff = '0;  prod = '0;  quo_s = '0;  rem_s = '0;
    case (state_q)
      IDLE: if (Start) begin
        f3_d    = Funct3;
        rd_d    = Rd_In;
        neg_a_d = sgn_a & SrcA[XLEN-1];
        neg_b_d = sgn_b & SrcB[XLEN-1];
        mag_a_d = neg_a_d ? -SrcA : SrcA;
        mag_b_d = neg_b_d ? -SrcB : SrcB;
        div0_d  = (SrcB == '0);
        ovf_d   = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
        cnt_d   = '0;
        // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
        acc_d   = Funct3[2] ? {{XLEN{1'b0}}, mag_a_d} : {{XLEN{1'b0}}, mag_b_d};
        if (early) begin
          res_d = Funct3[2] ? (Funct3[1] ? SrcA : '1) : '0;
          rdo_d = Rd_In;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (!f3_q[2]) begin
          mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
          acc_d   = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
          div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
          div_diff = div_sh - {1'b0, mag_b_q};
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {div_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
        end
      end
      FIX: begin
        rdo_d = rd_q;
        if (!f3_q[2]) begin
          prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
          res_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
          quo_s = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          rem_s = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
          if (div0_q) begin
            quo_s = '1;
            rem_s = neg_a_q ? -mag_a_q : mag_a_q;
          end
          if (ovf_q) begin
            quo_s = MIN_NEG;
            rem_s = '0;
          end
          res_d = f3_q[1] ? rem_s : quo_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      f3_q <= '0;  rd_q <= '0;  rdo_q <= '0;
      neg_a_q <= 1'b0;  neg_b_q <= 1'b0;  div0_q <= 1'b0;  ovf_q <= 1'b0;
      mag_a_q <= '0;  mag_b_q <= '0;  acc_q <= '0;  cnt_q <= '0;  res_q <= '0;
    end else begin
      f3_q <= f3_d;  rd_q <= rd_d;  rdo_q <= rdo_d;
      neg_a_q <= neg_a_d;  neg_b_q <= neg_b_d;  div0_q <= div0_d;  ovf_q <= ovf_d;
      mag_a_q <= mag_a_d;  mag_b_q <= mag_b_d;  acc_q <= acc_d;  cnt_q <= cnt_d;  res_q <= res_d;
    end
  end

  assign Result = res_q;
  assign Rd_Out = rdo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_unit;
  logic        CLK = 1'b0;
  logic        RST, Start, Busy, Done, WE_Out;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB, Result;
  logic [4:0]  Rd_In, Rd_Out;
  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Rd_In(Rd_In), .Busy(Busy), .Done(Done), .Result(Result), .Rd_Out(Rd_Out), .WE_Out(WE_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return 32'(sa / sb);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'h0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return (b == 0) ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  // One operation issued in the cycle after the previous DONE; disturb holds Start and scrambles inputs mid-op.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit disturb);
    logic [31:0] exp;
    int lat, k;
    bit seen;
    exp = ref_model(f, a, b);
    lat = exp_latency(b);
    @(negedge CLK);
    Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b; Rd_In = rd;
    @(posedge CLK); #1;
    if (!disturb) Start = 1'b0;
    else begin
      Rd_In = ~rd; Funct3 = ~f; SrcA = $urandom; SrcB = $urandom;
    end
    if (lat > 1) check("busy_after_start", 32'(Busy), 32'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 60) begin
      if (Done) seen = 1'b1;
      else begin
        @(posedge CLK); #1;
        k++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(k + 1), 32'(lat));
      check("result", Result, exp);
      check("rd_out", 32'(Rd_Out), 32'(rd));
      check("we_out", 32'(WE_Out), 32'd1);
      check("busy_in_done", 32'(Busy), 32'd0);
      @(posedge CLK); #1;
      Start = 1'b0;
      check("single_done", 32'(Done), 32'd0);
      check("result_hold", Result, exp);
    end
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int sel;
    bit seen;
    RST = 1'b0; Start = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0; Rd_In = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_we", 32'(WE_Out), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_rd", 32'(Rd_Out), 32'd0);
    @(negedge CLK) RST = 1'b1;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 1'b0);
    run_op(3'd5, 32'd100,        32'd7,         5'd7, 1'b0);
    run_op(3'd7, 32'd100,        32'd7,         5'd8, 1'b0);
    run_op(3'd4, 32'd5,          32'd0,         5'd9, 1'b0);
    run_op(3'd6, 32'd5,          32'd0,         5'd10, 1'b0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op(3'd0, 32'd1234,       32'd0,         5'd13, 1'b0);
    run_op(3'd1, 32'h1234_5678,  32'h9ABC_DEF0, 5'd14, 1'b1);
    run_op(3'd5, 32'hDEAD_BEEF,  32'd3,         5'd15, 1'b0);

    // Asynchronous reset in the middle of CALC.
    @(negedge CLK);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456; Rd_In = 5'd20;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_we", 32'(WE_Out), 32'd0);
    check("midrst_result", Result, 32'd0);
    check("midrst_rd", 32'(Rd_Out), 32'd0);
    @(negedge CLK) RST = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done) seen = 1'b1;
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    run_op(3'd0, 32'd123, 32'd456, 5'd21, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      run_op(f, a, b, 5'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It sits between the register file read ports and the register file write port. It takes the two source operands read for an M-extension instruction and holds the core stalled while it computes. It then presents one write-back beat (result, destination index, write enable) that the write-back mux routes to the register file's write data, write address and write enable inputs.

## Interface
- XLEN, 32, operand and result width.
- ADDR_W, 5, destination register index width.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- Start  input  1  request; sampled only in IDLE.
- Funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  rs1 value (multiplicand / dividend).
- SrcB  input  XLEN  rs2 value (multiplier / divisor).
- Rd_In  input  ADDR_W  destination index.
- Busy  output  1  high in CALC and FIX; core stalls PC while Busy or Done.
- Done  output  1  one-cycle result-valid strobe.
- Result  output  XLEN  result; valid while Done.
- Rd_Out  output  ADDR_W  latched destination index.
- WE_Out  output  1  register-file write enable; equals Done.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with Start=1:
  - latch Funct3, Rd_In and operand signs;
  - convert operands to magnitudes (signed for MULH/DIV/REM on both operands, SrcA only for MULHSU, none for unsigned ops);
  - clear 6-bit iteration counter;
  - go to CALC.
- IDLE with Start=0: remain in IDLE.
- CALC, multiply: one shift-add step per cycle into a 2*XLEN accumulator.
- CALC, divide: one restoring shift-subtract step per cycle. Quotient and remainder are both XLEN wide.
- CALC exits to FIX after exactly XLEN steps (counter 0..XLEN-1).
- FIX, multiply sign: negate the 2*XLEN product if operand signs differ (signed cases only).
- FIX, divide sign: negate the quotient if signs differ (DIV). The remainder takes the dividend's sign (REM).
- FIX, output select: MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits. Then go to DONE.
- Divide by zero: quotient all ones, remainder = SrcA. No trap.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same operands = 0.
- Both corner cases are forced in FIX, and latency is unchanged.
- DONE: Done=WE_Out=1 for one cycle, then IDLE.
- Result and Rd_Out hold their last values until the next DONE.
- Start is ignored outside IDLE. Funct3 and operand changes after the start edge have no effect.
- Reset, all outputs:
  - Busy=0, Done=0, WE_Out=0;
  - Result=0, Rd_Out=0;
  - state IDLE, counter 0, accumulators 0.
- Reset asserted mid-operation: immediately IDLE with the reset values above. The operation is abandoned and no Done is issued.

## Timing
- Start sampled high on edge E0.
- Busy is high from after E0 through the cycle before E33.
- CALC steps occur on E1..E32. FIX result registers on E33.
- Done/WE_Out/Result are valid in the cycle after E33, i.e. fixed 34-cycle latency. The write lands in the register file on E34.
- Back-to-back: Start may be high in the cycle after DONE; it is sampled on E34+1 (IDLE).
- No combinational path from inputs to outputs.

## Configuration
- MULDIV_EARLY_OUT_EN defined: SrcB==0 sampled at Start takes IDLE→DONE directly. Done appears in the cycle after E0 (latency 1). Results:
  - MUL*: 0;
  - DIV/DIVU: all ones;
  - REM/REMU: SrcA.
- MULDIV_EARLY_OUT_EN undefined: all operations, including SrcB==0, take the full 34 cycles with identical results.

## Test plan
- Reset mid-CALC: assert RST at cycle 10 → outputs 0 and IDLE. No Done follows, and the next Start completes normally.
- MUL 7×(-3), MULH 0xFFFFFFFF×0xFFFFFFFF, MULHU same operands, MULHSU 0xFFFFFFFF×2:
  - expected results 0xFFFFFFEB, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF;
  - each with Done exactly 34 cycles after Start.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV by zero with SrcA=5 → 0xFFFFFFFF; REM → 5. Latency 34 undefined, 1 with MULDIV_EARLY_OUT_EN.
- Overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Start held high during Busy, Rd_In changed mid-op:
  - Rd_Out keeps the original index;
  - a single Done strobe is issued;
  - a new op is accepted the cycle after DONE.
